btb: RTL and testbench
======================

Name: btb

Overview:
- Branch target buffer that receives the JAL target writes issued by the decode stage and answers the fetch stage's per-cycle prediction lookup.
- Also absorbs conditional-branch resolution from EX to train 2-bit saturating counters and to allocate taken branches.
- Sits between IF (query side), ID (b_we/b_waddr/b_wtarget write side) and EX (resolution side).

Parameters:
- IDX_W, 6, index bits; table holds 2**IDX_W entries.
- ADDR_W, 32, instruction address width.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- rdy  input  1  global ready; when low, table state frozen
- pc_i  input  ADDR_W  fetch PC to look up
- hit_o  output  1  pc_i matches a valid entry
- taken_o  output  1  predicted taken
- pred_pc_o  output  ADDR_W  next fetch PC: target if taken_o, else pc_i+4
- b_we_i  input  1  ID write request (unconditional jump)
- b_waddr_i  input  ADDR_W  PC of the jump
- b_wtarget_i  input  32  jump target
- u_we_i  input  1  EX resolution of a conditional branch
- u_addr_i  input  ADDR_W  PC of the resolved branch
- u_taken_i  input  1  actual outcome
- u_target_i  input  ADDR_W  actual taken target

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high on rst. On a rst-high edge, all valid bits clear; tag/target/counter contents are don't-care.
- Entry fields: valid, tag = addr[ADDR_W-1:IDX_W+2], target[ADDR_W-1:0], cnt[1:0]. Index = addr[IDX_W+1:2]; addr[1:0] is ignored.
- Lookup (combinational, from registered state):
  - hit_o = valid[idx(pc_i)] && tag matches.
  - taken_o = hit_o && cnt[1].
  - pred_pc_o = taken_o ? target : pc_i + 4, wrapping modulo 2**ADDR_W.
  - While rst is high: hit_o = 0, taken_o = 0, pred_pc_o = pc_i + 4.
- No write-through: a lookup in the same cycle as a write to the same index returns the pre-write contents. New contents are visible from the next cycle.
- ID write (b_we_i, rdy high, applied at the clock edge):
  - The entry at idx(b_waddr_i) is overwritten: valid = 1, tag, target = b_wtarget_i, cnt = 2'b11.
  - Any previous occupant, including an aliasing tag, is evicted.
- EX update (u_we_i, rdy high, applied at the clock edge):
  - Entry hit (valid and tag match): cnt increments saturating at 3 if u_taken_i, decrements saturating at 0 otherwise. If u_taken_i, target is also refreshed to u_target_i.
  - Entry miss and u_taken_i: allocate with valid = 1, tag, target = u_target_i, cnt = 2'b10, evicting the old occupant.
  - Entry miss and not taken: no change.
- Simultaneous ID write and EX update:
  - Different indices: both take effect in the same cycle.
  - Same index: the ID write wins completely and the EX update is dropped.
- rdy low: no table state changes; b_we_i and u_we_i are ignored, not queued. Lookup outputs continue to reflect the current state.
- rst mid-operation: rst overrides any concurrent write or update in that cycle. The table is empty from the next cycle.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.

Test Plan:
- Reset, then pc_i = 0x0000_1000 -> hit_o = 0, taken_o = 0, pred_pc_o = 0x0000_1004.
- ID write b_waddr_i = 0x1000, b_wtarget_i = 0x1200; same cycle pc_i = 0x1000 -> still miss (no write-through). Next cycle -> hit_o = 1, taken_o = 1, pred_pc_o = 0x1200.
- Train a branch:
  - EX taken at u_addr_i = 0x2008, u_target_i = 0x1F00 -> next cycle hit, cnt = 10, taken.
  - Two not-taken updates -> cnt 01 then 00, taken_o = 0, pred_pc_o = 0x200C.
  - A further not-taken update -> cnt stays 00.
- Alias: ID write at 0x1000, then ID write at 0x1100 (IDX_W = 6, same index 0) -> lookup 0x1000 misses, lookup 0x1100 hits.
- Same-cycle conflict and rdy gating:
  - b_we_i at 0x3000 (target 0x3400) together with u_we_i taken at 0x3000 (target 0x3800) -> target = 0x3400, cnt = 11.
  - Repeat with rdy = 0 -> no change.
- rst asserted in the same cycle as b_we_i -> the following cycle every lookup misses.

Source files
------------

// File: rtl/btb_if.sv
// Pipeline-side bundle of the branch target buffer: IF lookup, ID jump writes, EX resolution.
interface btb_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] pc_i;
    logic              hit_o;
    logic              taken_o;
    logic [ADDR_W-1:0] pred_pc_o;
    logic              b_we_i;
    logic [ADDR_W-1:0] b_waddr_i;
    logic [31:0]       b_wtarget_i;
    logic              u_we_i;
    logic [ADDR_W-1:0] u_addr_i;
    logic              u_taken_i;
    logic [ADDR_W-1:0] u_target_i;

    modport master (
        output pc_i, b_we_i, b_waddr_i, b_wtarget_i, u_we_i, u_addr_i, u_taken_i, u_target_i,
        input  hit_o, taken_o, pred_pc_o
    );

    modport slave (
        input  pc_i, b_we_i, b_waddr_i, b_wtarget_i, u_we_i, u_addr_i, u_taken_i, u_target_i,
        output hit_o, taken_o, pred_pc_o
    );
endinterface

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters; ID jump writes
// take priority over EX branch training on the same index.
module btb #(
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned ADDR_W = 32
) (
    input logic   clk,
    input logic   rst,
    input logic   rdy,
    btb_if.slave  bus
);
    localparam int unsigned Entries = 1 << IDX_W;
    localparam int unsigned TagW    = ADDR_W - IDX_W - 2;

    logic              valid_q [Entries];
    logic [TagW-1:0]   tag_q   [Entries];
    logic [ADDR_W-1:0] tgt_q   [Entries];
    logic [1:0]        cnt_q   [Entries];

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic [TagW-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:IDX_W+2];
    endfunction

    logic [IDX_W-1:0] q_idx;
    logic             q_hit;
    logic             q_taken;

    always_comb begin
        q_idx   = idx_of(bus.pc_i);
        q_hit   = !rst && valid_q[q_idx] && (tag_q[q_idx] == tag_of(bus.pc_i));
        q_taken = q_hit && cnt_q[q_idx][1];
    end

    assign bus.hit_o     = q_hit;
    assign bus.taken_o   = q_taken;
    assign bus.pred_pc_o = q_taken ? tgt_q[q_idx] : bus.pc_i + ADDR_W'(4);

    logic [IDX_W-1:0]  b_idx;
    logic [IDX_W-1:0]  u_idx;
    logic              u_hit;
    logic [1:0]        u_cnt_d;
    logic              ex_apply;
    logic [ADDR_W-1:0] b_tgt;

    always_comb begin
        b_idx   = idx_of(bus.b_waddr_i);
        u_idx   = idx_of(bus.u_addr_i);
        u_hit   = valid_q[u_idx] && (tag_q[u_idx] == tag_of(bus.u_addr_i));
        b_tgt   = ADDR_W'(bus.b_wtarget_i);
        u_cnt_d = 2'b10;
        if (u_hit) begin
            if (bus.u_taken_i) begin
                u_cnt_d = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'd1;
            end else begin
                u_cnt_d = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'd1;
            end
        end
        // A same-index ID write replaces the whole entry, so the EX update is dropped.
        ex_apply = bus.u_we_i && (u_hit || bus.u_taken_i) && !(bus.b_we_i && (b_idx == u_idx));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Entries); i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (rdy) begin
            if (bus.b_we_i) begin
                valid_q[b_idx] <= 1'b1;
                tag_q[b_idx]   <= tag_of(bus.b_waddr_i);
                tgt_q[b_idx]   <= b_tgt;
                cnt_q[b_idx]   <= 2'b11;
            end
            if (ex_apply) begin
                valid_q[u_idx] <= 1'b1;
                tag_q[u_idx]   <= tag_of(bus.u_addr_i);
                cnt_q[u_idx]   <= u_cnt_d;
                if (bus.u_taken_i) begin
                    tgt_q[u_idx] <= bus.u_target_i;
                end
            end
        end
    end

    // Word-aligned fetch: the byte-offset bits never reach the table.
    logic unused_bits;
    assign unused_bits = ^{bus.pc_i[1:0], bus.b_waddr_i[1:0], bus.u_addr_i[1:0]};

endmodule

// File: tb/tb_btb.sv
// Directed self-checking bench for btb: lookup, training, aliasing, conflicts, rdy and rst.
module tb_btb;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    btb_if #(.ADDR_W(32)) bus ();

    btb #(.IDX_W(6), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Look up pc and check all three outputs.
    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] pred);
        bus.pc_i = pc;
        #1;
        chk_bit({tag, "_hit"}, bus.hit_o, hit);
        chk_bit({tag, "_taken"}, bus.taken_o, taken);
        chk_word({tag, "_pred"}, bus.pred_pc_o, pred);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.b_we_i = 1'b0;
        bus.u_we_i = 1'b0;
    endtask

    task automatic ex_upd(input logic [31:0] addr, input logic taken, input logic [31:0] tgt);
        bus.u_we_i     = 1'b1;
        bus.u_addr_i   = addr;
        bus.u_taken_i  = taken;
        bus.u_target_i = tgt;
        tick();
        idle();
    endtask

    task automatic id_wr(input logic [31:0] addr, input logic [31:0] tgt);
        bus.b_we_i      = 1'b1;
        bus.b_waddr_i   = addr;
        bus.b_wtarget_i = tgt;
        tick();
        idle();
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.pc_i = 32'h0000_1000;
        bus.b_waddr_i = '0;
        bus.b_wtarget_i = '0;
        bus.u_addr_i = '0;
        bus.u_target_i = '0;
        bus.u_taken_i = 1'b0;
        idle();
        tick();
        look("in_rst", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
        tick();
        rst = 1'b0;
        #1;
        look("post_rst", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);

        // ID write: invisible this cycle, visible next.
        bus.b_we_i = 1'b1;
        bus.b_waddr_i = 32'h0000_1000;
        bus.b_wtarget_i = 32'h0000_1200;
        look("no_wthru", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
        tick();
        idle();
        look("id_hit", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1200);

        // Branch training at 0x2008.
        ex_upd(32'h0000_2008, 1'b1, 32'h0000_1F00);
        look("alloc10", 32'h0000_2008, 1'b1, 1'b1, 32'h0000_1F00);
        ex_upd(32'h0000_2008, 1'b0, 32'h0);
        look("cnt01", 32'h0000_2008, 1'b1, 1'b0, 32'h0000_200C);
        ex_upd(32'h0000_2008, 1'b0, 32'h0);
        look("cnt00", 32'h0000_2008, 1'b1, 1'b0, 32'h0000_200C);
        ex_upd(32'h0000_2008, 1'b0, 32'h0);
        // Saturated at 00: one taken update only reaches 01.
        ex_upd(32'h0000_2008, 1'b1, 32'h0000_1F40);
        look("sat_lo", 32'h0000_2008, 1'b1, 1'b0, 32'h0000_200C);
        ex_upd(32'h0000_2008, 1'b1, 32'h0000_1F80);
        look("retarget", 32'h0000_2008, 1'b1, 1'b1, 32'h0000_1F80);

        // Saturated at 11: taken keeps 11, one not-taken gives 10 (still taken).
        ex_upd(32'h0000_1000, 1'b1, 32'h0000_1200);
        ex_upd(32'h0000_1000, 1'b0, 32'h0);
        look("sat_hi", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_1200);

        // Not-taken miss leaves the table alone.
        ex_upd(32'h0000_2408, 1'b0, 32'h0);
        look("nt_miss", 32'h0000_2408, 1'b0, 1'b0, 32'h0000_240C);
        look("nt_keep", 32'h0000_2008, 1'b1, 1'b1, 32'h0000_1F80);

        // Aliasing on index 0.
        id_wr(32'h0000_1100, 32'h0000_1500);
        look("alias_old", 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004);
        look("alias_new", 32'h0000_1100, 1'b1, 1'b1, 32'h0000_1500);

        // Same-index conflict: ID wins with cnt 11.
        bus.b_we_i = 1'b1;
        bus.b_waddr_i = 32'h0000_3000;
        bus.b_wtarget_i = 32'h0000_3400;
        ex_upd(32'h0000_3000, 1'b1, 32'h0000_3800);
        look("conflict", 32'h0000_3000, 1'b1, 1'b1, 32'h0000_3400);
        ex_upd(32'h0000_3000, 1'b0, 32'h0);
        look("conflict_cnt", 32'h0000_3000, 1'b1, 1'b1, 32'h0000_3400);

        // Different indices in the same cycle both land.
        bus.b_we_i = 1'b1;
        bus.b_waddr_i = 32'h0000_4004;
        bus.b_wtarget_i = 32'h0000_4400;
        ex_upd(32'h0000_500C, 1'b1, 32'h0000_5800);
        look("dual_id", 32'h0000_4004, 1'b1, 1'b1, 32'h0000_4400);
        look("dual_ex", 32'h0000_500C, 1'b1, 1'b1, 32'h0000_5800);

        // rdy low: both requests ignored, lookup still live.
        rdy = 1'b0;
        bus.b_we_i = 1'b1;
        bus.b_waddr_i = 32'h0000_3000;
        bus.b_wtarget_i = 32'h0000_3C00;
        ex_upd(32'h0000_6000, 1'b1, 32'h0000_6800);
        look("rdy0_look", 32'h0000_3000, 1'b1, 1'b1, 32'h0000_3400);
        rdy = 1'b1;
        tick();
        look("rdy0_id", 32'h0000_3000, 1'b1, 1'b1, 32'h0000_3400);
        look("rdy0_ex", 32'h0000_6000, 1'b0, 1'b0, 32'h0000_6004);

        // rst overrides a concurrent write.
        rst = 1'b1;
        bus.b_we_i = 1'b1;
        bus.b_waddr_i = 32'h0000_7000;
        bus.b_wtarget_i = 32'h0000_7700;
        tick();
        idle();
        rst = 1'b0;
        look("rst_wr", 32'h0000_7000, 1'b0, 1'b0, 32'h0000_7004);
        look("rst_old", 32'h0000_3000, 1'b0, 1'b0, 32'h0000_3004);
        look("rst_old2", 32'h0000_2008, 1'b0, 1'b0, 32'h0000_200C);

        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
